masked_xor_arbiter: RTL

// - Shares one first-order masked XOR datapath (2 shares, share-wise XOR, no share mixing) among NREQ requesters.
// - Round-robin arbitration, valid/ready handshakes on both sides, registered shared result with requester ID.
// - Sits between masked cipher sub-blocks and the single XOR gadget they time-multiplex.

---
 rtl/masked_xor_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/masked_xor_arbiter.sv
// Round-robin arbiter sharing one first-order masked XOR gadget among NREQ requesters.
// Optional output refresh with fresh randomness: define MASKED_XOR_REFRESH_EN.
module masked_xor_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 2,
    parameter int IDW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef MASKED_XOR_REFRESH_EN
    input  logic [WIDTH-1:0]        rnd,
`endif
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a_0,
    input  logic [NREQ*WIDTH-1:0]   req_a_1,
    input  logic [NREQ*WIDTH-1:0]   req_b_0,
    input  logic [NREQ*WIDTH-1:0]   req_b_1,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_c_0,
    output logic [WIDTH-1:0]        rsp_c_1
);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic             slot_free;
    logic             fire;
    logic [WIDTH-1:0] a_0_sel, b_0_sel;
    logic [WIDTH-1:0] a_1_sel, b_1_sel;
    logic [WIDTH-1:0] c_0_next, c_1_next;

    assign slot_free = !rsp_valid || rsp_ready;

    // Scan from the round-robin pointer; the first valid requester wins.
    // NOTE: every variable gets a default at the top of always_comb, otherwise a latch is inferred.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && slot_free && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign fire = |req_ready;

    // Both share muxes use the same grant index; share 0 and share 1 never meet.
    assign a_0_sel = req_a_0[int'(grant_idx)*WIDTH +: WIDTH];
    assign b_0_sel = req_b_0[int'(grant_idx)*WIDTH +: WIDTH];
    assign a_1_sel = req_a_1[int'(grant_idx)*WIDTH +: WIDTH];
    assign b_1_sel = req_b_1[int'(grant_idx)*WIDTH +: WIDTH];

`ifdef MASKED_XOR_REFRESH_EN
    assign c_0_next = a_0_sel ^ b_0_sel ^ rnd;
    assign c_1_next = a_1_sel ^ b_1_sel ^ rnd;
`else
    assign c_0_next = a_0_sel ^ b_0_sel;
    assign c_1_next = a_1_sel ^ b_1_sel;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c_0   <= '0;
            rsp_c_1   <= '0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_idx;
            rsp_c_0   <= c_0_next;
            rsp_c_1   <= c_1_next;
            ptr       <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
